// File: rtl/writeback_if.sv
// Write-back stage bus: retire inputs, the decode-facing read port and status outputs.
// dbg_state carries the write-back FSM state for observation.
interface writeback_if #(
  parameter int DW = 64
);
  logic          wb_valid;
  logic [3:0]    icode;
  logic [3:0]    rA;
  logic [3:0]    rB;
  logic          cnd;
  logic [DW-1:0] valE;
  logic [DW-1:0] valM;
  logic [3:0]    rd_idx;
  logic [DW-1:0] rd_data;
  logic          halted;
  logic [31:0]   wr_count;
  logic          dbg_state;

  // wb_valid is a one-cycle commit strobe, sampled at the rising edge; there is
  // no ready: the register file accepts every strobe (it ignores them while halted).
  modport master (
    output wb_valid, icode, rA, rB, cnd, valE, valM, rd_idx,
    input  rd_data, halted, wr_count, dbg_state
  );

  modport slave (
    input  wb_valid, icode, rA, rB, cnd, valE, valM, rd_idx,
    output rd_data, halted, wr_count, dbg_state
  );
endinterface

// File: rtl/writeback.sv
// Y86-64 SEQ write-back stage owning the architectural register file, with a sticky halt.
module writeback #(
  parameter int       NREGS     = 15,
  parameter int       DW        = 64,
  parameter bit [3:0] RNONE     = 4'hF,
  parameter string    DUMP_FILE = "reg.txt"
) (
  input logic         clk,
  input logic         rst,
  writeback_if.slave  bus
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] NREGS_ID = 4'(NREGS);

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_regs [NREGS];
  logic [31:0]   r_wr_count;

  logic [3:0]    w_dst_e;
  logic [3:0]    w_dst_m;
  logic          w_commit;
  logic          w_we_e;
  logic          w_we_m;
  logic          w_same;
  logic [1:0]    w_nwr;

  always_comb begin
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (bus.icode)
      4'h2:                   w_dst_e = bus.cnd ? bus.rB : RNONE;
      4'h3, 4'h6:             w_dst_e = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: w_dst_e = 4'h4;
      default:                w_dst_e = RNONE;
    endcase
    case (bus.icode)
      4'h5, 4'hB: w_dst_m = bus.rA;
      default:    w_dst_m = RNONE;
    endcase
  end

  // IDs above the array but below RNONE are dropped rather than aliased.
  always_comb begin
    w_commit = (r_state == S_RUN) && bus.wb_valid;
    w_we_e   = w_commit && (w_dst_e != RNONE) && (w_dst_e < NREGS_ID);
    w_we_m   = w_commit && (w_dst_m != RNONE) && (w_dst_m < NREGS_ID);
    w_same   = w_we_e && w_we_m && (w_dst_e == w_dst_m);
    w_nwr    = w_same ? 2'd1 : ({1'b0, w_we_e} + {1'b0, w_we_m});
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:    if (bus.wb_valid && bus.icode == 4'h0) w_state_next = S_HALTED;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // When both ports target the same register (popq %rsp) the memory value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_we_e && !w_same) r_regs[w_dst_e] <= bus.valE;
      if (w_we_m)            r_regs[w_dst_m] <= bus.valM;
      r_wr_count <= r_wr_count + 32'(w_nwr);
    end
  end

  assign bus.rd_data   = (bus.rd_idx < NREGS_ID) ? r_regs[bus.rd_idx] : '0;
  assign bus.halted    = (r_state == S_HALTED);
  assign bus.wr_count  = r_wr_count;
  assign bus.dbg_state = r_state;

endmodule
